// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: instruction bus, data bus and SRAM pin bundle for ram_arbiter
interface ram_arbiter_if;
    logic [23:0] inst_addr;
    logic        inst_read;
    logic [31:0] inst_read_data;
    logic        inst_stall;
    logic [23:0] data_addr;
    logic [3:0]  data_byte_enable;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;
    logic        data_stall;
    logic [21:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_in;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    modport slave (
        input  inst_addr, inst_read, data_addr, data_byte_enable, data_read, data_write,
               data_write_data, sram_dq_in,
        output inst_read_data, inst_stall, data_read_data, data_stall, sram_addr,
               sram_dq_out, sram_dq_oe, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
    );
    modport master (
        output inst_addr, inst_read, data_addr, data_byte_enable, data_read, data_write,
               data_write_data, sram_dq_in,
        input  inst_read_data, inst_stall, data_read_data, data_stall, sram_addr,
               sram_dq_out, sram_dq_oe, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM port between a read-only instruction bus and a data bus,
// alternating grants under contention and stalling each side until its access completes.
module ram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_nx;
    logic        grant, last_grant, wr_q, inst_req, data_req, pick_data;
    logic [2:0]  cnt;
    logic [21:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q, inst_rd_q, data_rd_q;

    assign inst_req  = bus.inst_read;
    assign data_req  = bus.data_read | bus.data_write;
    // grant value 1 means DATA; under contention the side that did not win last time goes
    assign pick_data = data_req & (~inst_req | ~last_grant);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (inst_req | data_req) ? ACCESS : IDLE;
            ACCESS:  state_nx = (cnt == 3'd0) ? DONE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b0;
            wr_q       <= 1'b0;
            cnt        <= 3'd0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            inst_rd_q  <= '0;
            data_rd_q  <= '0;
        end else begin
            if (state == IDLE && (inst_req | data_req)) begin
                grant   <= pick_data;
                addr_q  <= pick_data ? bus.data_addr[23:2] : bus.inst_addr[23:2];
                be_q    <= pick_data ? bus.data_byte_enable : 4'hF;
                wdata_q <= bus.data_write_data;
                wr_q    <= pick_data & bus.data_write;
                cnt     <= 3'(WAIT_CYCLES);
            end
            if (state == ACCESS) begin
                if (cnt != 3'd0) cnt <= cnt - 3'd1;
                else begin
                    last_grant <= grant;
                    if (!wr_q && grant)  data_rd_q <= bus.sram_dq_in;
                    if (!wr_q && !grant) inst_rd_q <= bus.sram_dq_in;
                end
            end
        end
    end

    // strobes decode straight from state so an async reset releases the pads at once
    assign bus.sram_ce_n      = (state == IDLE);
    assign bus.sram_oe_n      = ~(state == ACCESS && !wr_q);
    assign bus.sram_we_n      = ~(state == ACCESS && wr_q);
    assign bus.sram_dq_oe     = (state != IDLE) && wr_q;
    assign bus.sram_be_n      = (state != IDLE) ? ~be_q : 4'hF;
    assign bus.sram_addr      = addr_q;
    assign bus.sram_dq_out    = wdata_q;
    assign bus.inst_read_data = inst_rd_q;
    assign bus.data_read_data = data_rd_q;
    assign bus.inst_stall     = inst_req & ~(state == DONE && !grant);
    assign bus.data_stall     = data_req & ~(state == DONE && grant);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table-driven checks plus corner sequences for ram_arbiter
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    ram_arbiter_if i1();
    ram_arbiter_if i0();
    ram_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    ram_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));

    always #5 clk = ~clk;

    logic [127:0] a1;
    assign a1 = {i1.inst_stall, i1.data_stall, i1.sram_ce_n, i1.sram_oe_n, i1.sram_we_n,
                 i1.sram_dq_oe, i1.sram_be_n, i1.sram_addr, i1.sram_dq_out,
                 i1.inst_read_data, i1.data_read_data};

    typedef struct {
        logic        ir, dr, dw;
        logic [23:0] a;
        logic [3:0]  be;
        logic [31:0] wd, din;
        logic [127:0] exp;
    } vec_t;
    vec_t tv[16];

    function automatic logic [127:0] ex(logic ist, logic dst, logic cen, logic oen, logic wen,
                                        logic doe, logic [3:0] ben, logic [21:0] sa,
                                        logic [31:0] dqo, logic [31:0] ird, logic [31:0] drd);
        return {ist, dst, cen, oen, wen, doe, ben, sa, dqo, ird, drd};
    endfunction

    function automatic vec_t v(logic ir, logic dr, logic dw, logic [23:0] a, logic [3:0] be,
                               logic [31:0] wd, logic [31:0] din, logic [127:0] e);
        vec_t r;
        r.ir = ir; r.dr = dr; r.dw = dw; r.a = a; r.be = be; r.wd = wd; r.din = din; r.exp = e;
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passed++;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        {i1.inst_read, i1.data_read, i1.data_write} = 3'b000;
        {i0.inst_read, i0.data_read, i0.data_write} = 3'b000;
        i1.inst_addr = '0; i1.data_addr = '0; i1.data_byte_enable = '0;
        i1.data_write_data = '0; i1.sram_dq_in = '0;
        i0.inst_addr = '0; i0.data_addr = '0; i0.data_byte_enable = '0;
        i0.data_write_data = '0; i0.sram_dq_in = '0;

        tv[0]  = v(0,0,0,24'h0,  4'h0,32'h0,    32'h0,       ex(0,0,1,1,1,0,4'hF,22'h0, 32'h0,32'h0,32'h0));
        tv[1]  = v(1,0,0,24'h104,4'h0,32'h0,    32'hDEADBEEF,ex(1,0,1,1,1,0,4'hF,22'h0, 32'h0,32'h0,32'h0));
        tv[2]  = v(1,0,0,24'h104,4'h0,32'h0,    32'hDEADBEEF,ex(1,0,0,0,1,0,4'h0,22'h41,32'h0,32'h0,32'h0));
        tv[3]  = v(1,0,0,24'h104,4'h0,32'h0,    32'hDEADBEEF,ex(1,0,0,0,1,0,4'h0,22'h41,32'h0,32'h0,32'h0));
        tv[4]  = v(1,0,0,24'h104,4'h0,32'h0,    32'hDEADBEEF,ex(0,0,0,1,1,0,4'h0,22'h41,32'h0,32'hDEADBEEF,32'h0));
        tv[5]  = v(0,0,0,24'h0,  4'h0,32'h0,    32'h0,       ex(0,0,1,1,1,0,4'hF,22'h41,32'h0,32'hDEADBEEF,32'h0));
        tv[6]  = v(0,0,1,24'h10, 4'h2,32'hAB00, 32'h12345678,ex(0,1,1,1,1,0,4'hF,22'h41,32'h0,32'hDEADBEEF,32'h0));
        tv[7]  = v(0,0,1,24'h10, 4'h2,32'hAB00, 32'h12345678,ex(0,1,0,1,0,1,4'hD,22'h4, 32'hAB00,32'hDEADBEEF,32'h0));
        tv[8]  = v(0,0,1,24'h10, 4'h2,32'hAB00, 32'h12345678,ex(0,1,0,1,0,1,4'hD,22'h4, 32'hAB00,32'hDEADBEEF,32'h0));
        tv[9]  = v(0,0,1,24'h10, 4'h2,32'hAB00, 32'h12345678,ex(0,0,0,1,1,1,4'hD,22'h4, 32'hAB00,32'hDEADBEEF,32'h0));
        tv[10] = v(0,0,0,24'h0,  4'h0,32'h0,    32'h0,       ex(0,0,1,1,1,0,4'hF,22'h4, 32'hAB00,32'hDEADBEEF,32'h0));
        tv[11] = v(0,1,0,24'h20, 4'hF,32'h0,    32'hCAFEF00D,ex(0,1,1,1,1,0,4'hF,22'h4, 32'hAB00,32'hDEADBEEF,32'h0));
        tv[12] = v(0,1,0,24'h20, 4'hF,32'h0,    32'hCAFEF00D,ex(0,1,0,0,1,0,4'h0,22'h8, 32'h0,32'hDEADBEEF,32'h0));
        tv[13] = v(0,1,0,24'h20, 4'hF,32'h0,    32'hCAFEF00D,ex(0,1,0,0,1,0,4'h0,22'h8, 32'h0,32'hDEADBEEF,32'h0));
        tv[14] = v(0,1,0,24'h20, 4'hF,32'h0,    32'hCAFEF00D,ex(0,0,0,1,1,0,4'h0,22'h8, 32'h0,32'hDEADBEEF,32'hCAFEF00D));
        tv[15] = v(0,0,0,24'h0,  4'h0,32'h0,    32'h0,       ex(0,0,1,1,1,0,4'hF,22'h8, 32'h0,32'hDEADBEEF,32'hCAFEF00D));

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            i1.inst_read = tv[k].ir; i1.data_read = tv[k].dr; i1.data_write = tv[k].dw;
            i1.inst_addr = tv[k].a; i1.data_addr = tv[k].a; i1.data_byte_enable = tv[k].be;
            i1.data_write_data = tv[k].wd; i1.sram_dq_in = tv[k].din;
            @(negedge clk);
            chk($sformatf("vec%0d", k), a1, tv[k].exp);
        end

        // zero wait states on the second instance
        @(posedge clk);
        #1 i0.data_read = 1'b1; i0.data_addr = 24'h40; i0.sram_dq_in = 32'h0BADF00D;
        @(negedge clk);
        chk("zw_c0", {i0.data_stall, i0.sram_ce_n}, 2'b11);
        cyc();
        chk("zw_c1", {i0.data_stall, i0.sram_ce_n, i0.sram_oe_n, i0.sram_addr}, {3'b100, 22'h10});
        cyc();
        chk("zw_c2", {i0.data_stall, i0.sram_ce_n, i0.sram_oe_n, i0.data_read_data}, {3'b001, 32'h0BADF00D});
        @(posedge clk);
        #1 i0.data_read = 1'b0;
        @(negedge clk);
        chk("zw_c3", {i0.data_stall, i0.sram_ce_n}, 2'b01);

        // reset asserted while a write is in ACCESS
        @(posedge clk);
        #1 i1.data_write = 1'b1; i1.data_addr = 24'h80; i1.data_byte_enable = 4'hF;
        i1.data_write_data = 32'h55AA55AA;
        cyc();
        chk("rst_pre", {i1.sram_we_n, i1.sram_ce_n}, 2'b00);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {i1.sram_we_n, i1.sram_ce_n, i1.sram_oe_n, i1.sram_dq_oe, i1.sram_be_n, i1.sram_addr},
               {4'b1110, 4'hF, 22'h0});
        @(posedge clk);
        #1 rst_n = 1'b1; i1.data_write = 1'b0; i1.data_read = 1'b1; i1.data_addr = 24'h84;
        i1.sram_dq_in = 32'h13579BDF;
        @(negedge clk);
        chk("rst_c0", {i1.data_stall, i1.sram_ce_n}, 2'b11);
        cyc();
        chk("rst_c1", {i1.sram_oe_n, i1.sram_we_n, i1.sram_addr}, {2'b01, 22'h21});
        cyc();
        cyc();
        chk("rst_c3", {i1.data_stall, i1.data_read_data}, {1'b0, 32'h13579BDF});
        @(posedge clk);
        #1 i1.data_read = 1'b0;

        // read and write together behave as a write
        @(posedge clk);
        #1 i1.data_read = 1'b1; i1.data_write = 1'b1; i1.data_addr = 24'hC0;
        i1.data_write_data = 32'hA5A5A5A5; i1.sram_dq_in = 32'hFFFFFFFF;
        cyc();
        chk("rw_c1", {i1.sram_we_n, i1.sram_oe_n, i1.sram_dq_oe, i1.sram_dq_out}, {3'b011, 32'hA5A5A5A5});
        cyc();
        cyc();
        chk("rw_c3", {i1.data_stall, i1.data_read_data}, {1'b0, 32'h13579BDF});
        @(posedge clk);
        #1 i1.data_read = 1'b0; i1.data_write = 1'b0;

        // contention from reset: DATA, INST, DATA, INST
        @(posedge clk);
        #1 rst_n = 1'b0; i1.inst_read = 1'b1; i1.data_read = 1'b1;
        i1.inst_addr = 24'h200; i1.data_addr = 24'h300;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("cont%0d", c), {i1.inst_stall, i1.data_stall},
                {(c % 8) != 7, (c % 8) != 3});
        end
        @(posedge clk);
        #1 i1.inst_read = 1'b0; i1.data_read = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
